// File: rtl/sdram_autorefresh_ctrl.sv
// SDRAM auto-refresh engine: accrues refresh debt on a fixed interval and, once granted the bus,
// issues PRECHARGE-all followed by up to REF_PER_REQ AUTO REFRESH commands. Optional macro: AUTOREF_URGENT_EN.
module sdram_autorefresh_ctrl #(
    parameter int REF_PERIOD_CYC = 750,
    parameter int CNT_W          = 10,
    parameter int TRP_CYC        = 2,
    parameter int TRFC_CYC       = 7,
    parameter int REF_PER_REQ    = 2,
    parameter int MAX_DEBT       = 8,
    parameter int DEBT_W         = 4,
    parameter int ADDR_W         = 12,
    parameter int URGENT_THRESH  = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              init_end_flag,
    input  logic              ref_en,
    output logic              ref_req,
    output logic              ref_end_flag,
    output logic [3:0]        ref_cmd,
    output logic [ADDR_W-1:0] ref_addr,
    output logic [DEBT_W-1:0] ref_debt,
    output logic              ref_urgent
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_TRP  = 3'd2;
    localparam logic [2:0] S_AREF = 3'd3;
    localparam logic [2:0] S_TRFC = 3'd4;
    localparam logic [2:0] S_END  = 3'd5;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    localparam int TMR_MAX = (TRP_CYC > TRFC_CYC) ? TRP_CYC : TRFC_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REF_PERIOD_CYC - 1);
    localparam logic [DEBT_W-1:0] MAX_D    = DEBT_W'(MAX_DEBT);
    // Per-grant cap never needs to exceed the saturated debt, so clip it to keep it in DEBT_W bits.
    localparam logic [DEBT_W-1:0] RPR_D    = (REF_PER_REQ >= MAX_DEBT) ? DEBT_W'(MAX_DEBT)
                                                                         : DEBT_W'(REF_PER_REQ);
    localparam logic [ADDR_W-1:0] ADDR_A10 = ADDR_W'(1) << 10;

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DEBT_W-1:0] r_debt;
    logic [DEBT_W-1:0] r_n;
    logic [DEBT_W-1:0] r_issued;
    logic [TMR_W-1:0]  r_tmr;
    logic [3:0]        r_cmd;
    logic [ADDR_W-1:0] r_addr;
    logic              r_end;

    logic              w_tick;
    logic [2:0]        w_nxt_state;
    logic [DEBT_W-1:0] w_nxt_n;
    logic [DEBT_W-1:0] w_nxt_issued;
    logic [TMR_W-1:0]  w_nxt_tmr;
    logic [DEBT_W-1:0] w_nxt_debt;
    logic [3:0]        w_nxt_cmd;

    assign w_tick = init_end_flag && (r_cnt == CNT_LAST);

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_n      = r_n;
        w_nxt_issued = r_issued;
        w_nxt_tmr    = r_tmr;
        case (r_state)
            S_IDLE: begin
                if (ref_en && (r_debt != '0)) begin
                    w_nxt_state  = S_PRE;
                    w_nxt_n      = (r_debt > RPR_D) ? RPR_D : r_debt;
                    w_nxt_issued = '0;
                end
            end
            S_PRE: begin
                if (TRP_CYC > 1) begin
                    w_nxt_state = S_TRP;
                    w_nxt_tmr   = TMR_W'(TRP_CYC - 2);
                end else begin
                    w_nxt_state  = S_AREF;
                    w_nxt_issued = r_issued + DEBT_W'(1);
                end
            end
            S_TRP: begin
                if (r_tmr == '0) begin
                    w_nxt_state  = S_AREF;
                    w_nxt_issued = r_issued + DEBT_W'(1);
                end else begin
                    w_nxt_tmr = r_tmr - TMR_W'(1);
                end
            end
            S_AREF: begin
                if (TRFC_CYC > 1) begin
                    w_nxt_state = S_TRFC;
                    w_nxt_tmr   = TMR_W'(TRFC_CYC - 2);
                end else if (r_issued < r_n) begin
                    w_nxt_state  = S_AREF;
                    w_nxt_issued = r_issued + DEBT_W'(1);
                end else begin
                    w_nxt_state = S_END;
                end
            end
            S_TRFC: begin
                if (r_tmr != '0) begin
                    w_nxt_tmr = r_tmr - TMR_W'(1);
                end else if (r_issued < r_n) begin
                    w_nxt_state  = S_AREF;
                    w_nxt_issued = r_issued + DEBT_W'(1);
                end else begin
                    w_nxt_state = S_END;
                end
            end
            S_END:   w_nxt_state = S_IDLE;
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // Retiring n refreshes always frees room, so a coincident tick cannot overflow.
    always_comb begin
        w_nxt_debt = r_debt;
        if (r_state == S_END)
            w_nxt_debt = r_debt - r_n + DEBT_W'(w_tick);
        else if (w_tick && (r_debt < MAX_D))
            w_nxt_debt = r_debt + DEBT_W'(1);
    end

    always_comb begin
        w_nxt_cmd = CMD_NOP;
        if (w_nxt_state == S_PRE)
            w_nxt_cmd = CMD_PRE;
        else if (w_nxt_state == S_AREF)
            w_nxt_cmd = CMD_AREF;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst || !init_end_flag) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_debt   <= '0;
            r_n      <= '0;
            r_issued <= '0;
            r_tmr    <= '0;
            r_cmd    <= CMD_NOP;
            r_addr   <= '0;
            r_end    <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_cnt    <= w_tick ? '0 : r_cnt + CNT_W'(1);
            r_debt   <= w_nxt_debt;
            r_n      <= w_nxt_n;
            r_issued <= w_nxt_issued;
            r_tmr    <= w_nxt_tmr;
            r_cmd    <= w_nxt_cmd;
            r_addr   <= (w_nxt_state == S_PRE) ? ADDR_A10 : '0;
            r_end    <= (w_nxt_state == S_END);
        end
    end

    assign ref_req      = (r_debt != '0) && (r_state == S_IDLE);
    assign ref_end_flag = r_end;
    assign ref_cmd      = r_cmd;
    assign ref_addr     = r_addr;
    assign ref_debt     = r_debt;

`ifdef AUTOREF_URGENT_EN
    assign ref_urgent = (r_debt >= DEBT_W'(URGENT_THRESH));
`else
    assign ref_urgent = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_autorefresh_ctrl.sv
// Randomized bench for sdram_autorefresh_ctrl against a schedule-based reference model
// (debt ledger plus command timing derived from the grant time).
module tb_sdram_autorefresh_ctrl;

    localparam int P     = 750;
    localparam int TRP   = 2;
    localparam int TRFC  = 7;
    localparam int RPR   = 2;
    localparam int MAXD  = 8;
    localparam int URG   = 4;
    localparam int NCYC  = 26000;

    logic        sys_clk;
    logic        sys_rst;
    logic        init_end_flag;
    logic        ref_en;
    logic        ref_req;
    logic        ref_end_flag;
    logic [3:0]  ref_cmd;
    logic [11:0] ref_addr;
    logic [3:0]  ref_debt;
    logic        ref_urgent;

    sdram_autorefresh_ctrl dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .init_end_flag(init_end_flag),
        .ref_en       (ref_en),
        .ref_req      (ref_req),
        .ref_end_flag (ref_end_flag),
        .ref_cmd      (ref_cmd),
        .ref_addr     (ref_addr),
        .ref_debt     (ref_debt),
        .ref_urgent   (ref_urgent)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: interval count, debt ledger, and an active grant described by its age.
    int m_cnt, m_debt, m_n, m_age;
    bit m_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int end_age();
        return TRP + m_n * TRFC;
    endfunction

    task automatic check_outputs();
        logic [3:0]  e_cmd;
        logic [11:0] e_addr;
        logic        e_end;
        e_cmd  = 4'b0111;
        e_addr = 12'h000;
        e_end  = 1'b0;
        if (m_busy) begin
            if (m_age == 0) begin
                e_cmd  = 4'b0010;
                e_addr = 12'h400;
            end else if (m_age >= TRP && m_age < end_age() && ((m_age - TRP) % TRFC) == 0) begin
                e_cmd = 4'b0001;
            end
            e_end = (m_age == end_age());
        end
        chk("cmd",  32'(ref_cmd),      32'(e_cmd));
        chk("addr", 32'(ref_addr),     32'(e_addr));
        chk("end",  32'(ref_end_flag), 32'(e_end));
        chk("debt", 32'(ref_debt),     32'(m_debt));
        chk("req",  32'(ref_req),      32'(!m_busy && m_debt != 0));
`ifdef AUTOREF_URGENT_EN
        chk("urgent", 32'(ref_urgent), 32'(m_debt >= URG));
`else
        chk("urgent", 32'(ref_urgent), 32'(0));
`endif
    endtask

    task automatic model_step(input bit rst_n, input bit init, input bit en);
        int tick;
        int old_debt;
        if (!rst_n || !init) begin
            m_cnt  = 0;
            m_debt = 0;
            m_busy = 0;
            m_age  = 0;
            return;
        end
        tick     = (m_cnt == P - 1) ? 1 : 0;
        m_cnt    = tick ? 0 : m_cnt + 1;
        old_debt = m_debt;
        if (m_busy && m_age == end_age()) begin
            m_debt = m_debt - m_n + tick;
            m_busy = 0;
        end else begin
            if (m_debt + tick <= MAXD) m_debt = m_debt + tick;
            if (m_busy) begin
                m_age++;
            end else if (en && old_debt != 0) begin
                m_busy = 1;
                m_age  = 0;
                m_n    = (old_debt < RPR) ? old_debt : RPR;
            end
        end
    endtask

    initial begin
        bit valid;
        bit r, i, e;
        sys_rst       = 1'b0;
        init_end_flag = 1'b0;
        ref_en        = 1'b0;
        m_cnt = 0; m_debt = 0; m_n = 0; m_age = 0; m_busy = 0;
        valid = 0;
        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge sys_clk);
            if (valid) check_outputs();
            if (cyc < 4) begin
                r = 0; i = 0; e = 0;
            end else if (cyc < 7000) begin
                // Long quiet stretch: debt should climb to and hold at saturation.
                r = 1; i = 1; e = 0;
            end else if (cyc < 16000) begin
                r = ($urandom % 1500) != 0;
                i = ($urandom % 400) != 0;
                e = ($urandom % 3) == 0;
            end else begin
                r = ($urandom % 4000) != 0;
                i = ($urandom % 1500) != 0;
                e = ($urandom % 40) == 0;
            end
            sys_rst       = r;
            init_end_flag = i;
            ref_en        = e;
            model_step(r, i, e);
            valid = 1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
